// File: rtl/led_control_pkg.sv
// Shared sizing defaults and the target-position type for the LED controller.
package led_control_pkg;
  localparam int N_LEDS      = 18;
  localparam int POS_W       = 5;
  localparam int SYNC_STAGES = 3;

  typedef logic [POS_W-1:0] pos_t;
endpackage

// File: rtl/led_control_if.sv
// Spawn request, switch inputs and LED mask of the whack-a-mole controller.
interface led_control_if #(
  parameter int N_LEDS = led_control_pkg::N_LEDS,
  parameter int POS_W  = led_control_pkg::POS_W
);
  logic              spawn_tick;
  logic [POS_W-1:0]  random_pos;
  logic [N_LEDS-1:0] sw;
  logic [N_LEDS-1:0] led_mask;

  modport master (output spawn_tick, random_pos, sw, input led_mask);
  modport slave  (input spawn_tick, random_pos, sw, output led_mask);
endinterface

// File: rtl/sw_sync_edge.sv
// Multi-stage synchronizer per input bit plus rising-edge detect on the synced level.
// Level valid STAGES edges after the input rises; rise is combinational off the last stage.
module sw_sync_edge #(
  parameter int WIDTH  = 18,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    sync_d[0] = din;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
endmodule

// File: rtl/led_control.sv
// Single-target LED controller: accepts a spawn only while idle, clears on a rising edge of the target switch.
// Spawn shows on led_mask the edge it is sampled; clear lands SYNC_STAGES+1 edges after the switch rises.
module led_control
  import led_control_pkg::*;
#(
  parameter int N_LEDS      = led_control_pkg::N_LEDS,
  parameter int POS_W       = led_control_pkg::POS_W,
  parameter int SYNC_STAGES = led_control_pkg::SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  led_control_if.slave bus
);
  logic              active_q, active_d;
  logic [POS_W-1:0]  target_q, target_d;
  logic [N_LEDS-1:0] led_mask_q, led_mask_d;
  logic [N_LEDS-1:0] press;
  logic [N_LEDS-1:0] sw_lvl_unused;
  logic              pos_ok;

  sw_sync_edge #(
    .WIDTH  (N_LEDS),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.sw),
    .level (sw_lvl_unused),
    .rise  (press)
  );

  // Extra bit keeps the range check correct when 2**POS_W == N_LEDS.
  assign pos_ok = {1'b0, bus.random_pos} < (POS_W+1)'(N_LEDS);

  always_comb begin
    active_d = active_q;
    target_d = target_q;
    if (active_q) begin
      if (press[target_q]) begin
        active_d = 1'b0;
      end
    end else if (bus.spawn_tick && pos_ok) begin
      active_d = 1'b1;
      target_d = bus.random_pos;
    end
    led_mask_d = active_d ? (N_LEDS'(1) << target_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= 1'b0;
      target_q   <= '0;
      led_mask_q <= '0;
    end else begin
      active_q   <= active_d;
      target_q   <= target_d;
      led_mask_q <= led_mask_d;
    end
  end

  assign bus.led_mask = led_mask_q;
endmodule

// File: tb/tb_led_control.sv
// Directed bench for led_control: inputs change on the falling edge, led_mask is checked on the falling edge.
module tb_led_control;
  import led_control_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  led_control_if #(.N_LEDS(N_LEDS), .POS_W(POS_W)) bus ();

  led_control #(
    .N_LEDS      (N_LEDS),
    .POS_W       (POS_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N_LEDS-1:0] oh(input int p);
    logic [N_LEDS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [N_LEDS-1:0] exp);
    vectors++;
    assert (bus.led_mask === exp) else begin
      miscompares++;
      $error("FAIL %s: led_mask=%h expected %h", tag, bus.led_mask, exp);
    end
  endtask

  task automatic spawn(input int p);
    bus.spawn_tick = 1'b1;
    bus.random_pos = pos_t'(p);
    cyc(1);
    bus.spawn_tick = 1'b0;
  endtask

  // Raise switch i, confirm LED still lit one edge before the clear, then gone on the 4th edge.
  task automatic press_clear(input int i, input string tag);
    bus.sw[i] = 1'b1;
    cyc(3);
    check({tag, "_before_clear"}, oh(i));
    cyc(1);
    check({tag, "_cleared"}, '0);
    bus.sw[i] = 1'b0;
    cyc(5);
  endtask

  initial begin
    int pos;
    int wrong;
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    bus.spawn_tick = 1'b0;
    bus.random_pos = '0;
    bus.sw         = '0;
    cyc(3);
    check("reset_state", '0);
    rst = 1'b0;
    cyc(2);
    check("idle_after_reset", '0);

    // Wrong switch held, then the right one.
    spawn(7);
    check("spawn7", 18'h00080);
    bus.sw[3] = 1'b1;
    cyc(6);
    check("wrong_sw3_held", 18'h00080);
    bus.sw[3] = 1'b0;
    cyc(5);
    check("after_sw3_release", 18'h00080);
    press_clear(7, "press7");

    // Spawn while active is dropped.
    spawn(12);
    check("spawn12", oh(12));
    spawn(5);
    check("spawn5_dropped", oh(12));
    cyc(2);
    check("spawn5_not_queued", oh(12));
    press_clear(12, "press12");

    // Reset mid-target.
    spawn(2);
    check("spawn2", 18'h00004);
    rst = 1'b1;
    cyc(1);
    check("rst_first_edge", '0);
    cyc(4);
    check("rst_held", '0);
    rst = 1'b0;
    cyc(3);
    check("rst_released", '0);

    // Position boundaries.
    spawn(20);
    check("pos20_ignored", '0);
    spawn(18);
    check("pos18_ignored", '0);
    spawn(17);
    check("pos17", 18'h20000);
    press_clear(17, "press17");
    spawn(0);
    check("pos0", 18'h00001);

    // Clear then a spawn on the very next edge.
    bus.sw[0] = 1'b1;
    cyc(4);
    check("press0_cleared", '0);
    spawn(9);
    check("spawn_after_clear", oh(9));
    bus.sw[0] = 1'b0;
    cyc(5);

    // Clear and spawn on the same edge: clear wins.
    bus.sw[9] = 1'b1;
    cyc(3);
    check("press9_before_clear", oh(9));
    bus.spawn_tick = 1'b1;
    bus.random_pos = pos_t'(3);
    cyc(1);
    bus.spawn_tick = 1'b0;
    check("clear_beats_spawn", '0);
    cyc(2);
    check("spawn_stays_dropped", '0);
    bus.sw[9] = 1'b0;
    cyc(5);

    // Switch already high before spawn: no edge, no clear until re-press.
    bus.sw[4] = 1'b1;
    cyc(6);
    spawn(4);
    check("spawn4_sw_high", 18'h00010);
    cyc(5);
    check("held_sw4_no_clear", 18'h00010);
    bus.sw[4] = 1'b0;
    cyc(5);
    check("sw4_released", 18'h00010);
    press_clear(4, "repress4");

    // Random rounds.
    for (int r = 0; r < 5; r++) begin
      pos = int'($urandom_range(0, N_LEDS - 1));
      spawn(pos);
      check("rnd_spawn", oh(pos));
      if ($urandom_range(0, 1) == 1) begin
        wrong = (pos + 1) % N_LEDS;
        bus.sw[wrong] = 1'b1;
        cyc(6);
        check("rnd_wrong_press", oh(pos));
        bus.sw[wrong] = 1'b0;
        cyc(5);
      end
      press_clear(pos, "rnd_press");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
